// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory port arbiter.
// Holds the FSM state encoding, owner codes and the latency counter sizing helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Width needed to hold a down-counter loaded with lat.
  function automatic int cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory block.
// slave is the arbiter's view; master is the view of the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, owner_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, owner_dma
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between CPU and DMA with a saturating starvation counter
// that forces a DMA grant after STARVE_MAX CPU grants made while DMA waited.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic arb_en,
  output logic grant_dma,
  output logic grant_any
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve;

  // CPU wins by default; DMA wins when alone or when it has been starved out.
  always_comb begin
    grant_any = cpu_req | dma_req;
    if (dma_req && (!cpu_req || (starve == SW'(STARVE_MAX)))) begin
      grant_dma = 1'b1;
    end else begin
      grant_dma = 1'b0;
    end
  end

  // Starvation counter, only evaluated while the arbiter is idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve <= '0;
    end else if (arb_en) begin
      if (!dma_req || grant_dma) begin
        starve <= '0;
      end else if (starve != SW'(STARVE_MAX)) begin
        starve <= starve + SW'(1);
      end else begin
        starve <= starve;
      end
    end else begin
      starve <= starve;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU controller and a DMA port: grants one
// requester, runs a fixed-latency access and returns data with a done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = cnt_w(MEM_LAT);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              we_lat;
  logic              grant_dma;
  logic              grant_any;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (bus.cpu_req),
    .dma_req   (bus.dma_req),
    .arb_en    (state == IDLE),
    .grant_dma (grant_dma),
    .grant_any (grant_any)
  );

  // Request fields of whichever requester wins this cycle.
  always_comb begin
    if (grant_dma) begin
      pick_we    = bus.dma_we;
      pick_addr  = bus.dma_addr;
      pick_wdata = bus.dma_wdata;
    end else begin
      pick_we    = bus.cpu_we;
      pick_addr  = bus.cpu_addr;
      pick_wdata = bus.cpu_wdata;
    end
  end

  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;

  // Access sequencer; mem_addr/mem_wdata double as the latched request fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      we_lat        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.owner_dma <= OWN_CPU;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_done  <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state         <= ISSUE;
            bus.busy      <= 1'b1;
            bus.owner_dma <= grant_dma ? OWN_DMA : OWN_CPU;
            we_lat        <= pick_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick_we;
            bus.mem_addr  <= pick_addr;
            bus.mem_wdata <= pick_wdata;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state      <= WAIT;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt        <= CW'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          // Last wait cycle: memory data is valid now.
          if (cnt == CW'(1)) begin
            state <= RESP;
            if (bus.owner_dma == OWN_DMA) begin
              bus.dma_ack <= 1'b1;
              if (!we_lat) begin
                bus.dma_rdata <= bus.mem_rdata;
              end
            end else begin
              bus.cpu_done <= 1'b1;
              if (!we_lat) begin
                bus.cpu_rdata <= bus.mem_rdata;
              end
            end
          end
        end
        RESP: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.cpu_done <= 1'b0;
          bus.dma_ack  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.mem_en   <= 1'b0;
          bus.mem_we   <= 1'b0;
          bus.cpu_done <= 1'b0;
          bus.dma_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3,
// each backed by a small memory model that returns data only in the valid cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] d3a;
  logic [31:0] d3b;

  // Memory models: read data is valid exactly MEM_LAT cycles after the issue cycle.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= (i == 4) ? 32'hDEAD_BEEF : 32'h0000_0000;
        mem3[i] <= (i == 4) ? 32'hDEAD_BEEF : 32'h0000_0000;
      end
      b1.mem_rdata <= 32'hBAD0_BAD0;
      d3a          <= 32'hBAD0_BAD0;
      d3b          <= 32'hBAD0_BAD0;
      b3.mem_rdata <= 32'hBAD0_BAD0;
    end else begin
      if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
      if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr[7:2]] <= b3.mem_wdata;
      b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr[7:2]] : 32'hBAD0_BAD0;
      d3a          <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr[7:2]] : 32'hBAD0_BAD0;
      d3b          <= d3a;
      b3.mem_rdata <= d3b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  logic [9:0] order;

  initial begin
    checks = 0;
    errors = 0;
    order  = 10'b1000010000;
    reset  = 1'b0;
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0; b1.cpu_wdata = 32'h0;
    b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_addr = 32'h0; b1.dma_wdata = 32'h0;
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h0; b3.cpu_wdata = 32'h0;
    b3.dma_req = 1'b0; b3.dma_we = 1'b0; b3.dma_addr = 32'h0; b3.dma_wdata = 32'h0;
    tick(); tick(); tick();

    chk1 ("rst_busy",      b1.busy,      1'b0);
    chk1 ("rst_mem_en",    b1.mem_en,    1'b0);
    chk1 ("rst_owner",     b1.owner_dma, 1'b0);
    chk1 ("rst_done",      b1.cpu_done,  1'b0);
    chk32("rst_cpu_rdata", b1.cpu_rdata, 32'h0);
    chk32("rst_dma_rdata", b1.dma_rdata, 32'h0);
    chk32("rst_mem_addr",  b1.mem_addr,  32'h0);
    reset = 1'b1;
    tick();

    // CPU read of 0x10 (T0 = this cycle)
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0000_0010;
    #1;
    chk1 ("rd_t0_stall", b1.cpu_stall, 1'b1);
    chk1 ("rd_t0_busy",  b1.busy,      1'b0);
    tick();
    chk1 ("rd_t1_en",    b1.mem_en,    1'b1);
    chk1 ("rd_t1_we",    b1.mem_we,    1'b0);
    chk32("rd_t1_addr",  b1.mem_addr,  32'h0000_0010);
    chk1 ("rd_t1_stall", b1.cpu_stall, 1'b1);
    chk1 ("rd_t1_owner", b1.owner_dma, 1'b0);
    tick();
    chk1 ("rd_t2_en",    b1.mem_en,    1'b0);
    chk1 ("rd_t2_done",  b1.cpu_done,  1'b0);
    chk1 ("rd_t2_stall", b1.cpu_stall, 1'b1);
    tick();
    chk1 ("rd_t3_done",  b1.cpu_done,  1'b1);
    chk32("rd_t3_rdata", b1.cpu_rdata, 32'hDEAD_BEEF);
    chk1 ("rd_t3_stall", b1.cpu_stall, 1'b0);
    b1.cpu_req = 1'b0;
    tick();
    chk1 ("rd_t4_done",  b1.cpu_done,  1'b0);
    chk1 ("rd_t4_busy",  b1.busy,      1'b0);
    chk32("rd_t4_hold",  b1.cpu_rdata, 32'hDEAD_BEEF);

    // DMA write of 0x12345678 to 0x40
    b1.dma_req = 1'b1; b1.dma_we = 1'b1; b1.dma_addr = 32'h0000_0040; b1.dma_wdata = 32'h1234_5678;
    tick();
    chk1 ("dw_t1_en",    b1.mem_en,    1'b1);
    chk1 ("dw_t1_we",    b1.mem_we,    1'b1);
    chk32("dw_t1_addr",  b1.mem_addr,  32'h0000_0040);
    chk32("dw_t1_wdata", b1.mem_wdata, 32'h1234_5678);
    chk1 ("dw_t1_owner", b1.owner_dma, 1'b1);
    tick();
    chk1 ("dw_t2_we",    b1.mem_we,    1'b0);
    tick();
    chk1 ("dw_t3_ack",   b1.dma_ack,   1'b1);
    chk1 ("dw_t3_cdone", b1.cpu_done,  1'b0);
    chk32("dw_t3_crd",   b1.cpu_rdata, 32'hDEAD_BEEF);
    chk32("dw_t3_drd",   b1.dma_rdata, 32'h0);
    b1.dma_req = 1'b0;
    tick();
    chk1 ("dw_t4_ack",   b1.dma_ack,   1'b0);

    // CPU reads back what the DMA wrote
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0000_0040;
    tick(); tick(); tick();
    chk1 ("rb_done",     b1.cpu_done,  1'b1);
    chk32("rb_rdata",    b1.cpu_rdata, 32'h1234_5678);
    chk32("rb_dma_rd",   b1.dma_rdata, 32'h0);
    b1.cpu_req = 1'b0;
    tick();

    // Request dropped mid-access, fields changed after latching
    b1.cpu_req = 1'b1; b1.cpu_addr = 32'h0000_0010;
    tick();
    b1.cpu_addr = 32'h0000_0020;
    tick();
    chk32("drop_addr_hold", b1.mem_addr, 32'h0000_0010);
    b1.cpu_req = 1'b0;
    tick();
    chk1 ("drop_done",   b1.cpu_done,  1'b1);
    chk32("drop_rdata",  b1.cpu_rdata, 32'hDEAD_BEEF);
    tick();
    chk1 ("drop_idle",   b1.busy,      1'b0);
    tick();
    chk1 ("drop_no_en",  b1.mem_en,    1'b0);
    chk1 ("drop_no_busy", b1.busy,     1'b0);

    // Contention: both held high, expect C,C,C,C,D,C,C,C,C,D
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0000_0010;
    b1.dma_req = 1'b1; b1.dma_we = 1'b0; b1.dma_addr = 32'h0000_0040;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk1("ct_owner", b1.owner_dma, order[k]);
      chk1("ct_en",    b1.mem_en,    1'b1);
      tick(); tick();
      chk1("ct_cdone", b1.cpu_done,  ~order[k]);
      chk1("ct_dack",  b1.dma_ack,   order[k]);
      tick();
    end
    chk32("ct_dma_rd", b1.dma_rdata, 32'h1234_5678);
    chk32("ct_cpu_rd", b1.cpu_rdata, 32'hDEAD_BEEF);
    b1.cpu_req = 1'b0; b1.dma_req = 1'b0;
    tick();

    // MEM_LAT=3: done at T5, back-to-back every 6 cycles
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h0000_0010;
    tick();
    chk1 ("l3_t1_en",    b3.mem_en,    1'b1);
    tick(); tick(); tick();
    chk1 ("l3_t4_done",  b3.cpu_done,  1'b0);
    chk1 ("l3_t4_stall", b3.cpu_stall, 1'b1);
    tick();
    chk1 ("l3_t5_done",  b3.cpu_done,  1'b1);
    chk32("l3_t5_rdata", b3.cpu_rdata, 32'hDEAD_BEEF);
    tick(); tick(); tick(); tick(); tick();
    chk1 ("l3_t10_done", b3.cpu_done,  1'b0);
    tick();
    chk1 ("l3_t11_done", b3.cpu_done,  1'b1);
    b3.cpu_req = 1'b0;
    tick();

    // Reset asserted during WAIT discards the access
    b1.cpu_req = 1'b1; b1.cpu_addr = 32'h0000_0040;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk1 ("mr_busy",     b1.busy,      1'b0);
    chk1 ("mr_en",       b1.mem_en,    1'b0);
    chk1 ("mr_done",     b1.cpu_done,  1'b0);
    chk32("mr_rdata",    b1.cpu_rdata, 32'h0);
    reset = 1'b1; b1.cpu_req = 1'b0;
    tick();
    chk1 ("mr_done2",    b1.cpu_done,  1'b0);
    chk1 ("mr_busy2",    b1.busy,      1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
